// File: rtl/packer.sv
// Nibble packer: gathers 4..24-bit MSB-aligned fields into a 64-bit buffer and
// emits 32-bit words MSB-first, with a flush that drains a zero-padded last word.
module packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] encPackData,
    input  logic        encPush4,
    input  logic        encPush8,
    input  logic        encPush12,
    input  logic        encPush16,
    input  logic        encPush20,
    input  logic        encPush24,
    input  logic        encFlush,
    output logic        encPackRdy,
    output logic [31:0] aes_ctxt,
    output logic        aes_ctxt_vld,
    input  logic        aes_ctxt_rdy,
    output logic        aes_ctxt_last,
    output logic        flushDone
);

    logic [63:0] packBuf, packBufNext;
    logic [4:0]  cnt, cntNext;
    logic        flushPend, flushPendNext;
    logic        flushDoneNext;

    logic [2:0]  pushLen;
    logic        inXfer, outXfer, flushClr;
    logic [4:0]  baseCnt;
    logic [63:0] shifted, fieldPos;
    logic [23:0] fieldMask;

    always_comb begin
        if      (encPush24) pushLen = 3'd6;
        else if (encPush20) pushLen = 3'd5;
        else if (encPush16) pushLen = 3'd4;
        else if (encPush12) pushLen = 3'd3;
        else if (encPush8)  pushLen = 3'd2;
        else if (encPush4)  pushLen = 3'd1;
        else                pushLen = 3'd0;
    end

    // Both sides are valid/ready: a transfer happens on a rising edge where the
    // sender's valid and the receiver's ready are both high. All valids and
    // readys driven by this block come from registers only, so there is no
    // combinational path from aes_ctxt_rdy to encPackRdy.
    assign encPackRdy    = !flushPend && (cnt <= 5'd10);
    assign aes_ctxt      = packBuf[63:32];
    assign aes_ctxt_vld  = (cnt >= 5'd8) || (flushPend && (cnt != 5'd0));
    assign aes_ctxt_last = flushPend && (cnt != 5'd0) && (cnt <= 5'd8);

    assign inXfer   = encPackRdy && ((pushLen != 3'd0) || encFlush);
    assign outXfer  = aes_ctxt_vld && aes_ctxt_rdy;
    assign flushClr = flushPend && ((outXfer && aes_ctxt_last) || (cnt == 5'd0));

    // Pop first, then land the push at the post-shift fill level.
    always_comb begin
        shifted = packBuf;
        baseCnt = cnt;
        if (outXfer) begin
            shifted = {packBuf[31:0], 32'd0};
            baseCnt = (cnt >= 5'd8) ? (cnt - 5'd8) : 5'd0;
        end
        fieldMask = ~(24'hFFFFFF >> {pushLen, 2'b00});
        fieldPos  = {encPackData & fieldMask, 40'd0} >> {baseCnt, 2'b00};

        packBufNext = shifted;
        cntNext     = baseCnt;
        if (inXfer) begin
            packBufNext = shifted | fieldPos;
            cntNext     = baseCnt + {2'b00, pushLen};
        end
    end

    always_comb begin
        flushPendNext = flushPend;
        if (inXfer && encFlush)
            flushPendNext = 1'b1;
        else if (flushClr)
            flushPendNext = 1'b0;
        flushDoneNext = flushClr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            packBuf   <= 64'd0;
            cnt       <= 5'd0;
            flushPend <= 1'b0;
            flushDone <= 1'b0;
        end else begin
            packBuf   <= packBufNext;
            cnt       <= cntNext;
            flushPend <= flushPendNext;
            flushDone <= flushDoneNext;
        end
    end

endmodule
